// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder: command opcodes,
// RV32I major opcodes, funct3/funct7 values and the controller state type.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5,
    OP_BNE  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENC   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // A 13-bit immediate fits a 12-bit I/S field only if its top two bits agree.
  function automatic logic imm_fits12(input logic [12:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: turns a command (op, registers, immediate)
// into a 32-bit instruction word and flags commands that cannot be encoded.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = {F7_ADD, rs2_i, rs1_i, F3_ADD, rd_i, OPC_RTYPE};
      OP_SUB:  word_o = {F7_SUB, rs2_i, rs1_i, F3_ADD, rd_i, OPC_RTYPE};
      OP_ADDI: begin
        word_o    = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_OPIMM};
        illegal_o = !imm_fits12(imm_i);
      end
      OP_LW: begin
        word_o    = {imm_i[11:0], rs1_i, F3_LW, rd_i, OPC_LOAD};
        illegal_o = !imm_fits12(imm_i);
      end
      OP_SW: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OPC_STORE};
        illegal_o = !imm_fits12(imm_i);
      end
      OP_BEQ, OP_BNE: begin
        // Branch offsets are halfword-aligned, so bit 0 is never stored.
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i,
                     (op_i == OP_BNE) ? F3_BNE : F3_BEQ,
                     imm_i[4:1], imm_i[11], OPC_BRANCH};
        illegal_o = imm_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Command-to-instruction-memory loader: accepts one command at a time, encodes
// it, and writes legal words to consecutive addresses until memory is full.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter  int IM_L = 16,
  localparam int AW   = $clog2(IM_L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [12:0]   in_imm,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(IM_L);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [2:0]    op_q;
  logic [4:0]    rd_q, rs1_q, rs2_q;
  logic [12:0]   imm_q;
  logic          im_we_q, err_q;
  logic [AW-1:0] im_addr_q;
  logic [31:0]   im_wdata_q;
  logic [31:0]   pack_word;
  logic          pack_illegal;
  logic          accept;

  instr_pack u_pack (
    .op_i      (op_q),
    .rd_i      (rd_q),
    .rs1_i     (rs1_q),
    .rs2_i     (rs2_q),
    .imm_i     (imm_q),
    .word_o    (pack_word),
    .illegal_o (pack_illegal)
  );

  assign full     = (count_q == FULL_CNT);
  assign in_ready = rst_n && (state_q == ST_IDLE) && !full && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (clear)       count_d = '0;
        else if (accept) state_d = ST_ENC;
      end
      ST_ENC: begin
        if (pack_illegal) begin
          state_d = ST_IDLE;
          if (clear) count_d = '0;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A clear raised mid-command takes effect as we return to idle.
        state_d = ST_IDLE;
        count_d = clear ? '0 : count_q + CNT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      im_we_q    <= 1'b0;
      err_q      <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      im_we_q <= (state_q == ST_ENC) && !pack_illegal;
      err_q   <= (state_q == ST_ENC) && pack_illegal;
      if (accept) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        imm_q <= in_imm;
      end
      if (state_q == ST_ENC) begin
        im_wdata_q <= pack_word;
        im_addr_q  <= count_q[AW-1:0];
      end
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign count    = count_q;
  assign err      = err_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter IM_L, default 16: instruction-memory depth in 32-bit words, a power of two, minimum 2.
REQ-002 SHALL have localparam AW, default $clog2(IM_L): instruction-memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  input  1  synchronous request to restart loading at address 0.
REQ-006 SHALL have port in_valid  input  1  command valid.
REQ-007 SHALL have port in_ready  output  1  command accepted when in_valid and in_ready are both high on a rising edge.
REQ-008 SHALL have port in_op  input  3  operation: 0 ADD, 1 SUB, 2 ADDI, 3 LW, 4 SW, 5 BEQ, 6 BNE, 7 illegal.
REQ-009 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 SHALL have port in_imm  input  13  signed immediate or branch offset.
REQ-011 SHALL have port im_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port im_addr  output  AW  instruction-memory word address.
REQ-013 SHALL have port im_wdata  output  32  encoded instruction word.
REQ-014 SHALL have port count  output  AW+1  number of words written since reset or clear.
REQ-015 SHALL have port full  output  1  high when count == IM_L.
REQ-016 SHALL have port err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-017 SHALL implement FSM IDLE -> ENC -> WRITE -> IDLE.
- IDLE: in_ready = !full && !clear.
- On accept: capture all command fields; go to ENC.
REQ-018 In ENC, SHALL form the 32-bit word and the legality check into registers, then go to WRITE, or to IDLE with err=1 if the command is illegal.
REQ-019 In WRITE, SHALL assert im_we for exactly one cycle with im_addr = count[AW-1:0], then increment count and return to IDLE.
- Latency: accept at edge N gives im_we high in cycle N+2.
- Throughput: one command per 3 cycles.
REQ-020 R-type encoding:
- {funct7, rs2, rs1, 000, rd, 0110011}.
- funct7 = 0000000 for ADD, 0100000 for SUB.
REQ-021 ADDI SHALL encode {imm[11:0], rs1, 000, rd, 0010011}; LW SHALL encode {imm[11:0], rs1, 010, rd, 0000011}.
REQ-022 SW SHALL encode {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
REQ-023 BEQ/BNE SHALL encode {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}, with f3 = 000 for BEQ and 001 for BNE.
REQ-024 A command SHALL be illegal when any of these holds:
- in_op == 7;
- ADDI/LW/SW with in_imm[12] != in_imm[11] (outside -2048..2047);
- BEQ/BNE with in_imm[0] == 1.
REQ-025 An illegal command SHALL NOT write memory and SHALL leave count unchanged.
REQ-026 When full, in_ready SHALL be 0 and commands SHALL stall; there SHALL be no wrap-around of im_addr.
REQ-027 clear in IDLE SHALL set count to 0 on the next edge; clear wins over a simultaneous in_valid.
REQ-028 clear in ENC or WRITE SHALL let the in-flight command complete, then zero count on return to IDLE (clear sampled high at that edge).

Reset
REQ-029 rst_n low SHALL asynchronously set:
- state = IDLE;
- count, im_we, im_addr, im_wdata, err = 0;
- in_ready = 0 while rst_n is low, and full = 0.
REQ-030 Reset asserted mid-operation SHALL abort the in-flight command with no memory write.

Structure
REQ-031 A shared package SHALL hold the opcode constants 0110011, 0010011, 0000011, 0100011 and 1100011, the funct3 and funct7 constants, and the in_op enumeration; the matching decode logic SHALL use the same package.
REQ-032 The combinational field packer SHALL be the sub-module instr_pack (op, regs, imm -> word, illegal); the FSM and count SHALL stay in instr_encoder.

Verification
REQ-033 ADD x3,x1,x2 then SUB x5,x6,x7 -> writes 0x002081B3 at addr 0 and 0x407302B3 at addr 1; count = 2.
REQ-034 ADDI x1,x0,-1 / LW x4,8(x2) / SW x5,12(x2) -> 0xFFF00093, 0x00812203, 0x00512623.
REQ-035 BEQ x1,x2,+8 / BNE x1,x2,-4 -> 0x00208463, 0xFE209EE3.
REQ-036 Illegal commands -> err pulse, no im_we, count unchanged:
- in_op = 7;
- ADDI with imm = 2048;
- BEQ with imm = 3.
REQ-037 Issue IM_L+1 commands -> full after the IM_L-th write, in_ready = 0, last im_addr = IM_L-1; then pulse clear -> count = 0, next write at addr 0.
REQ-038 Drop rst_n during WRITE -> im_we = 0 immediately and count = 0.
